pixel_readout_sink: RTL and testbench

//  Readout side of the pixel array interface. Controller side drives erase/expose/adc_enable
//  and waits for conversion done. This block then walks the array row by row: drives a
//  one-hot row select, waits for the column bus to settle, and latches one row of COLUMNS

---
 rtl/pixel_readout_sink_if.sv | 31 +++
 rtl/pixel_readout_sink.sv | 154 +++++++++++++++
 tb/tb_pixel_readout_sink.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_readout_sink_if.sv
// Pixel stream port of the readout sink.
//   m_data  : pixel word
//   m_valid : m_data and the markers are valid
//   m_ready : downstream accepts when m_valid && m_ready
//   m_sof   : marks row 0, column 0
//   m_eol   : marks the last column of a row
//   m_eof   : marks the last column of the last row
// Handshake: a word transfers on every rising edge where m_valid && m_ready.
// Once m_valid is high, m_data and the markers hold until that transfer, and
// m_valid only drops after a transfer.
// master = readout sink (source of pixels), slave = downstream consumer.
interface pixel_readout_sink_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_sof;
  logic             m_eol;
  logic             m_eof;

  modport master (
    output m_data, m_valid, m_sof, m_eol, m_eof,
    input  m_ready
  );

  modport slave (
    input  m_data, m_valid, m_sof, m_eol, m_eof,
    output m_ready
  );
endinterface

// File: rtl/pixel_readout_sink.sv
// Readout side of a pixel array. After read_start (ADC conversion done) the
// block walks the array row by row: it drives a one-hot row_select, waits
// SETTLE cycles for the column bus, latches the row, then streams the row one
// pixel at a time with start-of-frame / end-of-line / end-of-frame markers.
// Ports:
//   clk, reset  : clock (rising edge), synchronous active-high reset
//   read_start  : pulse, begin a frame readout (ignored while busy)
//   row_select  : one-hot row enable, 0 when no row is being selected/latched
//   pixel_bus   : column data, column c = pixel_bus[c*WIDTH +: WIDTH]
//   busy        : high from accepted read_start until frame_done
//   frame_done  : one-cycle pulse after the last pixel handshake
//   m           : pixel stream (pixel_readout_sink_if.master)
//   state_dbg   : current FSM state encoding
module pixel_readout_sink #(
  parameter int ROWS    = 10,
  parameter int COLUMNS = 10,
  parameter int WIDTH   = 8,
  parameter int SETTLE  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     read_start,
  output logic [ROWS-1:0]          row_select,
  input  logic [COLUMNS*WIDTH-1:0] pixel_bus,
  output logic                     busy,
  output logic                     frame_done,
  pixel_readout_sink_if.master     m,
  output logic [2:0]               state_dbg
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [RW-1:0] ROW_LAST    = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST    = CW'(COLUMNS - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    LATCH  = 3'd2,
    SHIFT  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           state;
  logic [RW-1:0]    row;
  logic [CW-1:0]    column;
  logic [SW-1:0]    settle;
  logic [WIDTH-1:0] buffer [COLUMNS];

  logic [CW-1:0] col_next;
  logic [RW-1:0] row_next;
  logic          col_next_last;
  logic          row_last;

  always_comb begin
    col_next      = column + CW'(1);
    row_next      = row + RW'(1);
    col_next_last = (col_next == COL_LAST);
    row_last      = (row == ROW_LAST);
  end

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      row        <= '0;
      column     <= '0;
      settle     <= '0;
      row_select <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      m.m_valid  <= 1'b0;
      m.m_data   <= '0;
      m.m_sof    <= 1'b0;
      m.m_eol    <= 1'b0;
      m.m_eof    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (read_start) begin
            state      <= SELECT;
            row        <= '0;
            settle     <= '0;
            row_select <= ROWS'(1);
            busy       <= 1'b1;
          end
        end

        SELECT: begin
          if (settle == SETTLE_LAST) begin
            state <= LATCH;
          end else begin
            settle <= settle + SW'(1);
          end
        end

        LATCH: begin
          // Capture the whole row so the array may move on while we stream.
          for (int c = 0; c < COLUMNS; c++) begin
            buffer[c] <= pixel_bus[c*WIDTH +: WIDTH];
          end
          // Column 0 goes straight from the bus to the output register.
          m.m_data   <= pixel_bus[WIDTH-1:0];
          m.m_valid  <= 1'b1;
          m.m_sof    <= (row == '0);
          m.m_eol    <= (COLUMNS == 1);
          m.m_eof    <= (COLUMNS == 1) && row_last;
          column     <= '0;
          row_select <= '0;
          state      <= SHIFT;
        end

        SHIFT: begin
          if (m.m_ready) begin
            if (column != COL_LAST) begin
              column   <= col_next;
              m.m_data <= buffer[col_next];
              m.m_sof  <= 1'b0;
              m.m_eol  <= col_next_last;
              m.m_eof  <= col_next_last && row_last;
            end else begin
              m.m_valid <= 1'b0;
              m.m_sof   <= 1'b0;
              m.m_eol   <= 1'b0;
              m.m_eof   <= 1'b0;
              if (!row_last) begin
                row        <= row_next;
                row_select <= ROWS'(1) << row_next;
                settle     <= '0;
                state      <= SELECT;
              end else begin
                state <= DONE;
              end
            end
          end
        end

        DONE: begin
          frame_done <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_readout_sink.sv
module tb_pixel_readout_sink;

  localparam int R  = 2;
  localparam int C  = 3;
  localparam int W  = 8;
  localparam int ST = 2;
  localparam int RD = 10;
  localparam int CD = 10;
  localparam int SD = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- small DUT (2x3) ----------------
  logic           read_start_s;
  logic [R-1:0]   sel_s;
  logic [C*W-1:0] pix_s;
  logic [C*W-1:0] noise_s;
  logic           busy_s, fd_s;
  logic [2:0]     state_s;
  logic [W-1:0]   arr_s [R][C];
  pixel_readout_sink_if #(.WIDTH(W)) bus_s ();

  pixel_readout_sink #(.ROWS(R), .COLUMNS(C), .WIDTH(W), .SETTLE(ST)) dut_s (
    .clk(clk), .reset(reset), .read_start(read_start_s), .row_select(sel_s),
    .pixel_bus(pix_s), .busy(busy_s), .frame_done(fd_s), .m(bus_s),
    .state_dbg(state_s)
  );

  // ---------------- default DUT (10x10) ----------------
  logic            read_start_d;
  logic [RD-1:0]   sel_d;
  logic [CD*W-1:0] pix_d;
  logic [CD*W-1:0] noise_d;
  logic            busy_d, fd_d;
  logic [2:0]      state_d;
  logic [W-1:0]    arr_d [RD][CD];
  pixel_readout_sink_if #(.WIDTH(W)) bus_d ();

  pixel_readout_sink dut_d (
    .clk(clk), .reset(reset), .read_start(read_start_d), .row_select(sel_d),
    .pixel_bus(pix_d), .busy(busy_d), .frame_done(fd_d), .m(bus_d),
    .state_dbg(state_d)
  );

  // Array model: the selected row drives the column bus; with no row selected
  // the bus carries noise that changes every cycle.
  always_comb begin
    pix_s = noise_s;
    for (int r = 0; r < R; r++)
      if (sel_s[r])
        for (int c = 0; c < C; c++) pix_s[c*W +: W] = arr_s[r][c];
  end

  always_comb begin
    pix_d = noise_d;
    for (int r = 0; r < RD; r++)
      if (sel_d[r])
        for (int c = 0; c < CD; c++) pix_d[c*W +: W] = arr_d[r][c];
  end

  initial begin
    noise_s = '0;
    noise_d = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int c = 0; c < C; c++) noise_s[c*W +: W] = W'($urandom);
      for (int c = 0; c < CD; c++) noise_d[c*W +: W] = W'($urandom);
    end
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W+2:0] exp_q[$];    // {sof, eol, eof, data}
  logic [W+2:0] exp_qd[$];
  logic [R-1:0] sel_log[$];
  int hs_count  = 0;
  int fd_count  = 0;
  int exp_fd    = 0;
  int pix_cnt_d = 0, sof_cnt_d = 0, eol_cnt_d = 0, eof_cnt_d = 0;
  int ready_mode = 0;          // 0: always ready, 1: toggle, 2: random

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- m_ready driver ----------------
  initial begin
    bus_s.m_ready = 1'b1;
    bus_d.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus_s.m_ready = 1'b1;
        1:       bus_s.m_ready = ~bus_s.m_ready;
        default: bus_s.m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- monitor: small DUT ----------------
  logic         prev_stall = 1'b0;
  logic [W+2:0] prev_word;
  logic [R-1:0] prev_sel = '0;

  initial begin
    logic [W+2:0] got, exp;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
        prev_sel   = '0;
      end else begin
        got = {bus_s.m_sof, bus_s.m_eol, bus_s.m_eof, bus_s.m_data};
        chk("row_select_onehot", ($countones(sel_s) <= 1), 1'b1);
        if (bus_s.m_valid) chk("row_select_zero_in_shift", sel_s, '0);
        if (prev_stall) begin
          chk("stall_valid_held", bus_s.m_valid, 1'b1);
          chk("stall_word_held", got, prev_word);
        end
        if (bus_s.m_valid && bus_s.m_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_pixel", got, '1);
            n_fail += (got === '1) ? 1 : 0;
          end else begin
            exp = exp_q.pop_front();
            chk("pixel_word", got, exp);
          end
          hs_count++;
        end
        if (fd_s) fd_count++;
        if (sel_s != '0 && sel_s != prev_sel) sel_log.push_back(sel_s);
        prev_sel   = sel_s;
        prev_stall = bus_s.m_valid && !bus_s.m_ready;
        prev_word  = got;
      end
    end
  end

  // ---------------- monitor: default DUT ----------------
  initial begin
    logic [W+2:0] got, exp;
    forever begin
      @(negedge clk);
      if (!reset && bus_d.m_valid) begin
        got = {bus_d.m_sof, bus_d.m_eol, bus_d.m_eof, bus_d.m_data};
        pix_cnt_d++;
        if (bus_d.m_sof) sof_cnt_d++;
        if (bus_d.m_eol) eol_cnt_d++;
        if (bus_d.m_eof) eof_cnt_d++;
        if (exp_qd.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pixel_d: got 0x%0h expected none", got);
        end else begin
          exp = exp_qd.pop_front();
          chk("pixel_word_d", got, exp);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_frame_s();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        exp_q.push_back({(r == 0 && c == 0), (c == C-1), (c == C-1 && r == R-1), arr_s[r][c]});
  endtask

  task automatic randomize_arr_s();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) arr_s[r][c] = W'($urandom);
  endtask

  // Runs one frame. Latency counted in edges from the edge that samples
  // read_start to the edge that raises frame_done.
  task automatic run_frame(input int mode, input bit mid_start, input bit check_lat);
    int n;
    ready_mode = mode;
    push_frame_s();
    exp_fd++;
    sel_log.delete();
    @(posedge clk); #1;
    read_start_s = 1'b1;
    @(posedge clk); #1;
    read_start_s = 1'b0;
    chk("busy_after_start", busy_s, 1'b1);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
      if (mid_start && n == 4) read_start_s = 1'b1;
      if (mid_start && n == 5) read_start_s = 1'b0;
    end while (!fd_s && n < 2000);
    chk("frame_done_seen", fd_s, 1'b1);
    chk("busy_low_at_done", busy_s, 1'b0);
    if (check_lat) chk("frame_latency", n, R*(ST+1+C)+1);
    chk("row_select_sequence_len", sel_log.size(), R);
    for (int i = 0; i < sel_log.size() && i < R; i++)
      chk("row_select_value", sel_log[i], R'(1) << i);
    @(posedge clk); #1;
    chk("frame_done_one_cycle", fd_s, 1'b0);
    chk("leftover_pixels", exp_q.size(), 0);
  endtask

  task automatic run_abort();
    int base, n;
    ready_mode = 0;
    push_frame_s();
    base = hs_count;
    @(posedge clk); #1;
    read_start_s = 1'b1;
    @(posedge clk); #1;
    read_start_s = 1'b0;
    n = 0;
    while (hs_count < base + 2 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("abort_two_pixels_seen", (hs_count >= base + 2), 1'b1);
    #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("reset_mid_m_valid", bus_s.m_valid, 1'b0);
    chk("reset_mid_row_select", sel_s, '0);
    chk("reset_mid_busy", busy_s, 1'b0);
    chk("reset_mid_frame_done", fd_s, 1'b0);
    chk("reset_mid_m_data", bus_s.m_data, '0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("abandoned_no_frame_done", fd_count, exp_fd);
    chk("abandoned_idle_busy", busy_s, 1'b0);
  endtask

  task automatic run_default_frame();
    int n;
    for (int r = 0; r < RD; r++)
      for (int c = 0; c < CD; c++) begin
        arr_d[r][c] = W'($urandom);
        exp_qd.push_back({(r == 0 && c == 0), (c == CD-1), (c == CD-1 && r == RD-1), arr_d[r][c]});
      end
    @(posedge clk); #1;
    read_start_d = 1'b1;
    @(posedge clk); #1;
    read_start_d = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!fd_d && n < 2000);
    chk("default_frame_done_seen", fd_d, 1'b1);
    chk("default_frame_latency", n, RD*(SD+1+CD)+1);
    chk("default_pixel_count", pix_cnt_d, RD*CD);
    chk("default_sof_count", sof_cnt_d, 1);
    chk("default_eol_count", eol_cnt_d, RD);
    chk("default_eof_count", eof_cnt_d, 1);
    chk("default_leftover", exp_qd.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset        = 1'b1;
    read_start_s = 1'b0;
    read_start_d = 1'b0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) arr_s[r][c] = W'(r*C + c + 1);
    for (int r = 0; r < RD; r++)
      for (int c = 0; c < CD; c++) arr_d[r][c] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_row_select", sel_s, '0);
    chk("reset_busy", busy_s, 1'b0);
    chk("reset_frame_done", fd_s, 1'b0);
    chk("reset_m_valid", bus_s.m_valid, 1'b0);
    chk("reset_m_data", bus_s.m_data, '0);
    chk("reset_markers", {bus_s.m_sof, bus_s.m_eol, bus_s.m_eof}, 3'b000);
    chk("reset_default_row_select", sel_d, '0);
    reset = 1'b0;

    // Fixed frame [1,2,3],[4,5,6]: free-flowing, then toggled ready.
    run_frame(0, 1'b0, 1'b1);
    run_frame(1, 1'b0, 1'b0);
    // read_start mid-frame must be ignored.
    run_frame(0, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    chk("mid_start_ignored_busy", busy_s, 1'b0);
    // Reset after the second accepted pixel, then a clean frame.
    run_abort();
    run_frame(0, 1'b0, 1'b1);
    // Random contents with assorted backpressure.
    for (int i = 0; i < 6; i++) begin
      randomize_arr_s();
      run_frame(i % 3, 1'b0, (i % 3) == 0);
    end

    run_default_frame();

    repeat (5) @(negedge clk);
    chk("frame_done_total", fd_count, exp_fd);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
